// File: rtl/obi_mem_responder.sv
// OBI memory responder: byte-enabled word RAM behind a req/gnt address phase,
// with a programmable grant stall and an in-order, age-timed response queue.
module obi_mem_responder #(
    parameter int ADDR_WIDTH      = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   req_i,
    output logic                                   gnt_o,
    input  logic [31:0]                            addr_i,
    input  logic                                   we_i,
    input  logic [3:0]                             be_i,
    input  logic [31:0]                            wdata_i,
    output logic                                   rvalid_o,
    output logic [31:0]                            rdata_o,
    input  logic [3:0]                             gnt_stall_i,
    input  logic [3:0]                             rvalid_lat_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int IW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IW;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    state_e          state_r;
    state_e          state_s;
    logic [3:0]      scnt_r;
    logic [3:0]      scnt_s;
    logic            gnt_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            rvalid_s;
    logic [IW-1:0]   widx_s;
    logic            unused_addr_s;

    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [CW-1:0]   count_r;
    logic            q_we_r   [MAX_OUTSTANDING];
    logic [31:0]     q_data_r [MAX_OUTSTANDING];
    logic [3:0]      q_age_r  [MAX_OUTSTANDING];

    logic [31:0]     mem_r    [DEPTH];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // Upper address bits alias and the byte offset is ignored.
    assign widx_s        = addr_i[ADDR_WIDTH-1:2];
    assign unused_addr_s = ^{addr_i[31:ADDR_WIDTH], addr_i[1:0]};

    assign full_s   = (count_r == FULL_CNT);
    assign push_s   = req_i && gnt_o;
    assign rvalid_s = (count_r != {CW{1'b0}}) && (q_age_r[rptr_r] == 4'd0);
    assign pop_s    = rvalid_s;

    // Grant FSM state and stall counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            scnt_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            scnt_r  <= scnt_s;
        end
    end

    // Grant FSM next state; a dropped request in STALL returns to IDLE.
    always_comb begin
        state_s = state_r;
        scnt_s  = scnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i && (gnt_stall_i == 4'd0) && !full_s) begin
                    state_s = ST_IDLE;
                    scnt_s  = 4'd0;
                end else if (req_i) begin
                    state_s = ST_STALL;
                    scnt_s  = 4'd1;
                end else begin
                    state_s = ST_IDLE;
                    scnt_s  = 4'd0;
                end
            end
            ST_STALL: begin
                if (!req_i) begin
                    state_s = ST_IDLE;
                    scnt_s  = 4'd0;
                end else if ((scnt_r >= gnt_stall_i) && !full_s) begin
                    state_s = ST_IDLE;
                    scnt_s  = 4'd0;
                end else begin
                    state_s = ST_STALL;
                    scnt_s  = (scnt_r == 4'd15) ? 4'd15 : scnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                scnt_s  = 4'd0;
            end
        endcase
    end

    // Grant FSM output; the stall limit is compared live.
    always_comb begin
        gnt_s = 1'b0;
        case (state_r)
            ST_IDLE:  gnt_s = req_i && (gnt_stall_i == 4'd0) && !full_s;
            ST_STALL: gnt_s = req_i && (scnt_r >= gnt_stall_i) && !full_s;
            default:  gnt_s = 1'b0;
        endcase
    end

    assign gnt_o = gnt_s && !rst_i;

    // Response queue: capture at handshake, age every entry, pop the head at age 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_we_r[i]   <= 1'b0;
                q_data_r[i] <= 32'd0;
                q_age_r[i]  <= 4'd0;
            end
        end else begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_age_r[i] <= (q_age_r[i] == 4'd0) ? 4'd0 : q_age_r[i] - 4'd1;
            end
            if (push_s) begin
                q_we_r[wptr_r]   <= we_i;
                q_data_r[wptr_r] <= we_i ? 32'd0 : mem_r[widx_s];
                q_age_r[wptr_r]  <= rvalid_lat_i;
                wptr_r           <= ptr_inc(wptr_r);
            end else begin
                wptr_r <= wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ptr_inc(rptr_r);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Word RAM with byte-enabled writes; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (push_s && we_i) begin
            mem_r[widx_s] <= merge_bytes(mem_r[widx_s], wdata_i, be_i);
        end else begin
            mem_r[widx_s] <= mem_r[widx_s];
        end
    end

    assign rvalid_o      = rvalid_s && !rst_i;
    assign rdata_o       = (rvalid_o && !q_we_r[rptr_r]) ? q_data_r[rptr_r] : 32'd0;
    assign outstanding_o = rst_i ? {CW{1'b0}} : count_r;

endmodule
